// File: rtl/adder_compare_seq_if.sv
// Bus between the adder self-check sequencer and its surroundings:
// run control, operand drive to both adders, adder results and run status.
interface adder_compare_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             abort;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             op_cin;
   logic [WIDTH-1:0] cla_sum;
   logic             cla_cout;
   logic [WIDTH-1:0] cra_sum;
   logic             cra_cout;
   logic             busy;
   logic             done;
   logic             pass;
   logic [15:0]      err_count;
   logic [15:0]      first_err_idx;
   logic [15:0]      vec_idx;

   // Sequencer side
   modport master (
      input  start, abort, cla_sum, cla_cout, cra_sum, cra_cout,
      output op_a, op_b, op_cin, busy, done, pass, err_count, first_err_idx, vec_idx
   );

   // Environment side (adders and run controller)
   modport slave (
      output start, abort, cla_sum, cla_cout, cra_sum, cra_cout,
      input  op_a, op_b, op_cin, busy, done, pass, err_count, first_err_idx, vec_idx
   );
endinterface

// File: rtl/adder_compare_seq.sv
// Self-check sequencer for a CLA/CRA adder pair. Drives NUM_VECTORS operand
// sets from two Galois LFSRs, lets both adders settle, compares
// {cout,sum} of the two and keeps a saturating mismatch count plus the index
// of the first failing vector.
// Optional feature macro: ADDER_CORNER_VEC_EN -- vectors 0..3 become fixed
// corner cases and the LFSRs hold while they are applied.
module adder_compare_seq #(
   parameter int          WIDTH         = 32,
   parameter int          NUM_VECTORS   = 1000,
   parameter int          SETTLE_CYCLES = 2,
   parameter logic [31:0] SEED          = 32'hACE12468
) (
   input logic                 clk,
   input logic                 rst_n,
   adder_compare_seq_if.master bus
);

   localparam logic [31:0] LFSR_MASK   = 32'h80200003;
   localparam logic [15:0] LAST_VEC    = 16'(NUM_VECTORS - 1);
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] IDX_NONE    = 16'hFFFF;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SETTLE = 3'd2,
      S_CHECK  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t           state_r;
   state_t           state_s;
   state_t           nat_s;
   logic [31:0]      lfsr_a_r;
   logic [31:0]      lfsr_b_r;
   logic [WIDTH-1:0] op_a_r;
   logic [WIDTH-1:0] op_b_r;
   logic             op_cin_r;
   logic [15:0]      settle_cnt_r;
   logic             busy_r;
   logic             done_r;
   logic             pass_r;
   logic [15:0]      err_count_r;
   logic [15:0]      first_err_idx_r;
   logic [15:0]      vec_idx_r;
   logic             abort_s;
   logic             mismatch_s;

   // One Galois step, right-shifting, x^32+x^22+x^2+x+1
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      if (s[0]) begin
         lfsr_step = {1'b0, s[31:1]} ^ LFSR_MASK;
      end else begin
         lfsr_step = {1'b0, s[31:1]};
      end
   endfunction

`ifdef ADDER_CORNER_VEC_EN
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] PAT_55   = WIDTH'(32'h55555555);
   localparam logic [WIDTH-1:0] PAT_AA   = WIDTH'(32'hAAAAAAAA);

   // Corner operand A for vectors 0..3
   function automatic logic [WIDTH-1:0] corner_a(input logic [1:0] idx);
      case (idx)
         2'd0:    corner_a = ALL_ZERO;
         2'd1:    corner_a = ALL_ONES;
         2'd2:    corner_a = ALL_ONES;
         2'd3:    corner_a = PAT_55;
         default: corner_a = ALL_ZERO;
      endcase
   endfunction

   // Corner operand B for vectors 0..3
   function automatic logic [WIDTH-1:0] corner_b(input logic [1:0] idx);
      case (idx)
         2'd0:    corner_b = ALL_ZERO;
         2'd1:    corner_b = ALL_ZERO;
         2'd2:    corner_b = ALL_ONES;
         2'd3:    corner_b = PAT_AA;
         default: corner_b = ALL_ZERO;
      endcase
   endfunction
`endif

   // Abort only counts outside IDLE; compare the full 33-bit results
   always_comb begin
      abort_s    = bus.abort && (state_r != S_IDLE);
      mismatch_s = ({bus.cla_cout, bus.cla_sum} != {bus.cra_cout, bus.cra_sum});
   end

   // Next-state logic; abort overrides every natural transition
   always_comb begin
      nat_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (bus.start) nat_s = S_LOAD;
            else           nat_s = S_IDLE;
         end
         S_LOAD:   nat_s = S_SETTLE;
         S_SETTLE: begin
            if (settle_cnt_r == SETTLE_LAST) nat_s = S_CHECK;
            else                             nat_s = S_SETTLE;
         end
         S_CHECK: begin
            if (vec_idx_r < LAST_VEC) nat_s = S_LOAD;
            else                      nat_s = S_DONE;
         end
         S_DONE:  nat_s = S_IDLE;
         default: nat_s = S_IDLE;
      endcase
      if (abort_s) state_s = S_IDLE;
      else         state_s = nat_s;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= S_IDLE;
      else        state_r <= state_s;
   end

   // Status flags: busy follows the state being entered, done trails DONE by one edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state_s == S_LOAD) || (state_s == S_SETTLE) || (state_s == S_CHECK);
         done_r <= (state_r == S_DONE) && !abort_s;
      end
   end

   // Datapath: run init, operand load, settle timer, compare and bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_a_r        <= SEED;
         lfsr_b_r        <= ~SEED;
         op_a_r          <= {WIDTH{1'b0}};
         op_b_r          <= {WIDTH{1'b0}};
         op_cin_r        <= 1'b0;
         settle_cnt_r    <= 16'd0;
         pass_r          <= 1'b0;
         err_count_r     <= 16'd0;
         first_err_idx_r <= IDX_NONE;
         vec_idx_r       <= 16'd0;
      end else if (!abort_s) begin
         case (state_r)
            S_IDLE: begin
               if (bus.start) begin
                  lfsr_a_r        <= SEED;
                  lfsr_b_r        <= ~SEED;
                  err_count_r     <= 16'd0;
                  first_err_idx_r <= IDX_NONE;
                  vec_idx_r       <= 16'd0;
               end
            end
            S_LOAD: begin
               settle_cnt_r <= 16'd0;
`ifdef ADDER_CORNER_VEC_EN
               if (vec_idx_r < 16'd4) begin
                  op_a_r   <= corner_a(vec_idx_r[1:0]);
                  op_b_r   <= corner_b(vec_idx_r[1:0]);
                  op_cin_r <= (vec_idx_r[1:0] == 2'd1) || (vec_idx_r[1:0] == 2'd2);
               end else begin
                  op_a_r   <= lfsr_a_r[WIDTH-1:0];
                  op_b_r   <= lfsr_b_r[WIDTH-1:0];
                  op_cin_r <= lfsr_a_r[31] ^ lfsr_b_r[31];
                  lfsr_a_r <= lfsr_step(lfsr_a_r);
                  lfsr_b_r <= lfsr_step(lfsr_b_r);
               end
`else
               op_a_r   <= lfsr_a_r[WIDTH-1:0];
               op_b_r   <= lfsr_b_r[WIDTH-1:0];
               op_cin_r <= lfsr_a_r[31] ^ lfsr_b_r[31];
               lfsr_a_r <= lfsr_step(lfsr_a_r);
               lfsr_b_r <= lfsr_step(lfsr_b_r);
`endif
            end
            S_SETTLE: begin
               settle_cnt_r <= settle_cnt_r + 16'd1;
            end
            S_CHECK: begin
               if (mismatch_s) begin
                  if (err_count_r != 16'hFFFF) err_count_r <= err_count_r + 16'd1;
                  if (first_err_idx_r == IDX_NONE) first_err_idx_r <= vec_idx_r;
               end
               if (vec_idx_r < LAST_VEC) vec_idx_r <= vec_idx_r + 16'd1;
            end
            S_DONE: begin
               pass_r <= (err_count_r == 16'd0);
            end
            default: begin
               settle_cnt_r <= 16'd0;
            end
         endcase
      end
   end

   assign bus.op_a          = op_a_r;
   assign bus.op_b          = op_b_r;
   assign bus.op_cin        = op_cin_r;
   assign bus.busy          = busy_r;
   assign bus.done          = done_r;
   assign bus.pass          = pass_r;
   assign bus.err_count     = err_count_r;
   assign bus.first_err_idx = first_err_idx_r;
   assign bus.vec_idx       = vec_idx_r;

endmodule
